// File: rtl/ysyx_22050243_lsu_pkg.sv
// ysyx_22050243_lsu_pkg: size encodings, FSM states and alignment helpers for the LSU
package ysyx_22050243_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   // unshifted byte-lane mask for an access size
   function automatic logic [7:0] size_bmask(input logic [1:0] size);
      return size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
   endfunction

   // address not naturally aligned to the access size
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
      return size == SZ_H ? a[0] : size == SZ_W ? |a[1:0] : size == SZ_D ? |a : 1'b0;
   endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_align.sv
// ysyx_22050243_lsu_align: store lane shift/mask expansion and load shift/extension
module ysyx_22050243_lsu_align
   import ysyx_22050243_lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [2:0]  st_off,
   input  logic [63:0] st_wdata,
   output logic [63:0] st_data,
   output logic [63:0] st_wmask,
   input  logic [1:0]  ld_size,
   input  logic [2:0]  ld_off,
   input  logic        ld_unsigned,
   input  logic [63:0] ld_raw,
   output logic [63:0] ld_data
);

   logic [7:0]  bmask;
   logic [63:0] r;
   logic        sx;

   assign bmask   = size_bmask(st_size) << st_off;
   assign st_data = st_wdata << {st_off, 3'b000};

   for (genvar g = 0; g < 8; g++) begin : g_mask
      assign st_wmask[8*g +: 8] = {8{bmask[g]}};
   end

   // bring the addressed lane down to bit 0, truncate and extend
   always_comb begin
      r       = ld_raw >> {ld_off, 3'b000};
      sx      = ~ld_unsigned;
      ld_data = ld_size == SZ_B ? {{56{sx & r[7]}}, r[7:0]} :
                ld_size == SZ_H ? {{48{sx & r[15]}}, r[15:0]} :
                ld_size == SZ_W ? {{32{sx & r[31]}}, r[31:0]} : r;
   end

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// ysyx_22050243_lsu: single-outstanding load/store unit driving the shared 64-bit data port
module ysyx_22050243_lsu
   import ysyx_22050243_lsu_pkg::*;
#(
   parameter int MEM_LATENCY = 1,
   parameter int XLEN        = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic            ex_store,
   input  logic [1:0]      ex_size,
   input  logic            ex_unsigned,
   input  logic [XLEN-1:0] ex_addr,
   input  logic [XLEN-1:0] ex_wdata,
   input  logic [4:0]      ex_rd,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [XLEN-1:0] wb_rdata,
   output logic [4:0]      wb_rd,
   output logic            wb_misalign,
   output logic            data_r_en,
   output logic            data_w_en,
   output logic [XLEN-1:0] data_addr,
   output logic [XLEN-1:0] data_w,
   output logic [XLEN-1:0] data_wmask,
   input  logic [XLEN-1:0] data_r
);

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        store_q, store_d, uns_q, uns_d;
   logic [1:0]  size_q, size_d;
   logic [2:0]  off_q, off_d;
   logic [4:0]  rd_q, rd_d;
   logic        ex_ready_q, ex_ready_d, wb_valid_q, wb_valid_d, wb_mis_q, wb_mis_d;
   logic [63:0] wb_rdata_q, wb_rdata_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        r_en_q, r_en_d, w_en_q, w_en_d;
   logic [63:0] addr_q, addr_d, w_q, w_d, wmask_q, wmask_d;
   logic [63:0] st_data, st_wmask, ld_data;

   ysyx_22050243_lsu_align u_align (
      .st_size    (ex_size),
      .st_off     (ex_addr[2:0]),
      .st_wdata   (ex_wdata),
      .st_data    (st_data),
      .st_wmask   (st_wmask),
      .ld_size    (size_q),
      .ld_off     (off_q),
      .ld_unsigned(uns_q),
      .ld_raw     (data_r),
      .ld_data    (ld_data)
   );

   // next-state and next-output logic; every output is registered
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      store_d    = store_q;
      uns_d      = uns_q;
      size_d     = size_q;
      off_d      = off_q;
      rd_d       = rd_q;
      ex_ready_d = ex_ready_q;
      wb_valid_d = wb_valid_q;
      wb_mis_d   = wb_mis_q;
      wb_rdata_d = wb_rdata_q;
      wb_rd_d    = wb_rd_q;
      r_en_d     = r_en_q;
      w_en_d     = w_en_q;
      addr_d     = addr_q;
      w_d        = w_q;
      wmask_d    = wmask_q;
      case (state_q)
         IDLE: if (ex_valid) begin
            store_d    = ex_store;
            uns_d      = ex_unsigned;
            size_d     = ex_size;
            off_d      = ex_addr[2:0];
            rd_d       = ex_rd;
            ex_ready_d = 1'b0;
            if (misaligned(ex_size, ex_addr[2:0])) begin
               state_d    = RESP;
               wb_valid_d = 1'b1;
               wb_mis_d   = 1'b1;
            end else begin
               state_d = ACCESS;
               cnt_d   = CNT_INIT;
               r_en_d  = ~ex_store;
               w_en_d  = ex_store;
               addr_d  = {ex_addr[XLEN-1:3], 3'b000};
               w_d     = st_data;
               wmask_d = st_wmask;
            end
         end
         ACCESS: begin
            w_en_d = 1'b0;
            cnt_d  = cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               cnt_d      = 4'd0;
               wb_valid_d = 1'b1;
               wb_rdata_d = store_q ? 64'd0 : ld_data;
               wb_rd_d    = store_q ? 5'd0 : rd_q;
               r_en_d     = 1'b0;
               addr_d     = 64'd0;
               w_d        = 64'd0;
               wmask_d    = 64'd0;
            end
         end
         RESP: if (wb_ready) begin
            state_d    = IDLE;
            ex_ready_d = 1'b1;
            wb_valid_d = 1'b0;
            wb_mis_d   = 1'b0;
            wb_rdata_d = 64'd0;
            wb_rd_d    = 5'd0;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         store_q    <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= SZ_B;
         off_q      <= 3'd0;
         rd_q       <= 5'd0;
         ex_ready_q <= 1'b1;
         wb_valid_q <= 1'b0;
         wb_mis_q   <= 1'b0;
         wb_rdata_q <= 64'd0;
         wb_rd_q    <= 5'd0;
         r_en_q     <= 1'b0;
         w_en_q     <= 1'b0;
         addr_q     <= 64'd0;
         w_q        <= 64'd0;
         wmask_q    <= 64'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         store_q    <= store_d;
         uns_q      <= uns_d;
         size_q     <= size_d;
         off_q      <= off_d;
         rd_q       <= rd_d;
         ex_ready_q <= ex_ready_d;
         wb_valid_q <= wb_valid_d;
         wb_mis_q   <= wb_mis_d;
         wb_rdata_q <= wb_rdata_d;
         wb_rd_q    <= wb_rd_d;
         r_en_q     <= r_en_d;
         w_en_q     <= w_en_d;
         addr_q     <= addr_d;
         w_q        <= w_d;
         wmask_q    <= wmask_d;
      end
   end

   assign ex_ready    = ex_ready_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rdata    = wb_rdata_q;
   assign wb_rd       = wb_rd_q;
   assign wb_misalign = wb_mis_q;
   assign data_r_en   = r_en_q;
   assign data_w_en   = w_en_q;
   assign data_addr   = addr_q;
   assign data_w      = w_q;
   assign data_wmask  = wmask_q;

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// tb_ysyx_22050243_lsu: randomized scoreboard bench with a byte-array memory reference model
module tb_ysyx_22050243_lsu;
   import ysyx_22050243_lsu_pkg::*;

   localparam int LAT = 3;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_store = 1'b0, ex_unsigned = 1'b0, wb_ready = 1'b0;
   logic [1:0]  ex_size = 2'd0;
   logic [63:0] ex_addr = 64'd0, ex_wdata = 64'd0, data_r;
   logic [4:0]  ex_rd = 5'd0;
   logic        ex_ready, wb_valid, wb_misalign, data_r_en, data_w_en;
   logic [63:0] wb_rdata, data_addr, data_w, data_wmask;
   logic [4:0]  wb_rd;

   ysyx_22050243_lsu #(.MEM_LATENCY(LAT), .XLEN(64)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_store(ex_store),
      .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .ex_rd(ex_rd), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdata(wb_rdata), .wb_rd(wb_rd),
      .wb_misalign(wb_misalign), .data_r_en(data_r_en), .data_w_en(data_w_en),
      .data_addr(data_addr), .data_w(data_w), .data_wmask(data_wmask), .data_r(data_r)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] rdata;
      logic [4:0]  rd;
      logic        mis;
      longint      t;
      int          ren;
      int          wen;
      logic [63:0] addr;
      logic [63:0] mask;
      logic [63:0] w;
   } exp_t;

   exp_t        q[$];
   int          checks = 0, errors = 0;
   logic [7:0]  ref_b[256];
   logic [63:0] mem[32];
   logic [63:0] junk = 64'd0;
   int          rcnt = 0;
   bit          stall = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic preload(input int idx, input logic [63:0] v);
      mem[idx] = v;
      for (int i = 0; i < 8; i++) ref_b[idx*8+i] = v[8*i +: 8];
   endtask

   function automatic logic [63:0] ref_load(input logic [7:0] a, input int n, input bit uns);
      logic [63:0] v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[8'(a + i)];
      if ((!uns || n == 8) && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   // memory slave: data_r is only valid once the read enable has been held LAT cycles
   assign data_r = (data_r_en && rcnt == LAT-1) ? mem[data_addr[7:3]] : junk;
   always @(posedge clk) begin
      junk <= {$urandom, $urandom};
      rcnt <= data_r_en ? rcnt + 1 : 0;
   end
   always @(posedge clk)
      if (data_w_en) mem[data_addr[7:3]] = (mem[data_addr[7:3]] & ~data_wmask) | (data_w & data_wmask);

   initial begin
      forever begin
         @(posedge clk);
         #1 wb_ready = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
   end

   task automatic do_op(input bit st, input logic [1:0] sz, input bit un, input logic [63:0] a,
                        input logic [63:0] wd, input logic [4:0] rd);
      exp_t e;
      int   n = 1 << sz;
      int   w = 0;
      @(negedge clk);
      ex_valid = 1'b1; ex_store = st; ex_size = sz; ex_unsigned = un;
      ex_addr = a; ex_wdata = wd; ex_rd = rd;
      while (!ex_ready && w < 50) begin @(negedge clk); w++; end
      if (!ex_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: ex_ready stuck at %b, required 1", ex_ready);
         ex_valid = 1'b0;
         return;
      end
      @(posedge clk);
      e.mis   = (int'(a[2:0]) % n) != 0;
      e.t     = $time + 5 + (e.mis ? 0 : LAT*10);
      e.ren   = (!st && !e.mis) ? LAT : 0;
      e.wen   = (st && !e.mis) ? 1 : 0;
      e.addr  = a & ~64'h7;
      e.mask  = 64'd0;
      e.w     = 64'd0;
      for (int i = 0; i < n && !e.mis; i++) begin
         e.mask[8*(int'(a[2:0])+i) +: 8] = 8'hFF;
         e.w[8*(int'(a[2:0])+i) +: 8]    = wd[8*i +: 8];
      end
      e.rdata = (st || e.mis) ? 64'd0 : ref_load(a[7:0], n, un);
      e.rd    = (st || e.mis) ? 5'd0 : rd;
      if (st && !e.mis) for (int i = 0; i < n; i++) ref_b[8'(a[7:0] + i)] = wd[8*i +: 8];
      q.push_back(e);
      #1 ex_valid = 1'b0;
   endtask

   // monitor: protocol checks every cycle, scoreboard compare on each WB handshake
   int          ren = 0, wen = 0;
   bit          pv = 1'b0, pr = 1'b0;
   logic [63:0] prdata;
   logic [5:0]  pside;
   always @(negedge clk) begin
      if (!rst_n) begin
         ren = 0; wen = 0; pv = 1'b0;
      end else begin
         if (data_r_en) ren++;
         if (data_w_en) wen++;
         if (data_w_en && q.size() != 0) begin
            chk("wr_addr", data_addr, q[0].addr);
            chk("wr_mask", data_wmask, q[0].mask);
            chk("wr_data", data_w & q[0].mask, q[0].w);
         end
         if (data_r_en && q.size() != 0) chk("rd_addr", data_addr, q[0].addr);
         if (ex_ready || wb_valid)
            chk("mem_idle", data_addr | data_w | data_wmask | {62'd0, data_r_en, data_w_en}, 64'd0);
         if (pv && !pr) begin
            chk("hold_valid", {63'd0, wb_valid}, 64'd1);
            chk("hold_rdata", wb_rdata, prdata);
            chk("hold_rd_mis", {58'd0, wb_rd, wb_misalign}, {58'd0, pside});
         end
         if (wb_valid) begin
            chk("busy_ready", {63'd0, ex_ready}, 64'd0);
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_resp: wb_valid=1 with no op outstanding at %0t", $time);
            end else begin
               if (!pv) chk("latency", 64'($time), 64'(q[0].t));
               if (wb_ready) begin
                  chk("wb_rdata", wb_rdata, q[0].rdata);
                  chk("wb_rd", {59'd0, wb_rd}, {59'd0, q[0].rd});
                  chk("wb_misalign", {63'd0, wb_misalign}, {63'd0, q[0].mis});
                  chk("r_en_cycles", 64'(ren), 64'(q[0].ren));
                  chk("w_en_cycles", 64'(wen), 64'(q[0].wen));
                  void'(q.pop_front());
                  ren = 0; wen = 0;
               end
            end
         end
         pv = wb_valid; pr = wb_ready; prdata = wb_rdata; pside = {wb_rd, wb_misalign};
      end
   end

   task automatic chk_reset_outputs();
      chk("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
      chk("rst_wb", {57'd0, wb_valid, wb_rd, wb_misalign}, 64'd0);
      chk("rst_wb_rdata", wb_rdata, 64'd0);
      chk("rst_en", {62'd0, data_r_en, data_w_en}, 64'd0);
      chk("rst_mem_port", data_addr | data_w | data_wmask, 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      logic [1:0] sz;
      logic [63:0] a;
      for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});
      repeat (2) @(negedge clk);
      chk_reset_outputs();
      rst_n = 1'b1;
      preload(0, 64'h0000_0000_8000_0000);
      do_op(1'b0, SZ_B, 1'b0, 64'h8000_0003, 64'd0, 5'd7);
      do_op(1'b0, SZ_B, 1'b1, 64'h8000_0003, 64'd0, 5'd8);
      do_op(1'b1, SZ_H, 1'b0, 64'h8000_0006, 64'h1234, 5'd3);
      do_op(1'b0, SZ_H, 1'b1, 64'h8000_0006, 64'd0, 5'd4);
      do_op(1'b0, SZ_W, 1'b0, 64'h8000_0002, 64'd0, 5'd9);
      do_op(1'b0, SZ_D, 1'b0, 64'h8000_0008, 64'd0, 5'd10);
      do_op(1'b0, SZ_W, 1'b0, 64'h8000_0010, 64'd0, 5'd11);
      stall = 1'b1;
      w = 0;
      while (!wb_valid && w < 50) begin @(negedge clk); w++; end
      repeat (5) begin
         @(negedge clk);
         ex_valid = 1'($urandom); ex_store = 1'($urandom); ex_size = 2'($urandom);
         ex_addr = 64'h8000_0000 | 64'($urandom_range(0, 255));
      end
      @(negedge clk);
      ex_valid = 1'b0;
      stall = 1'b0;
      do_op(1'b0, SZ_D, 1'b0, 64'h8000_0018, 64'd0, 5'd12);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs();
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      preload(0, 64'hDEADBEEF_00000000);
      do_op(1'b0, SZ_W, 1'b1, 64'h8000_0004, 64'd0, 5'd13);
      for (int k = 0; k < 60; k++) begin
         sz = 2'($urandom);
         a  = 64'h8000_0000 | 64'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
         do_op($urandom_range(0, 9) < 4, sz, 1'($urandom), a, {$urandom, $urandom}, 5'($urandom));
      end
      w = 0;
      while (q.size() != 0 && w < 500) begin @(negedge clk); w++; end
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d responses outstanding, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22050243_lsu.md
Name: ysyx_22050243_lsu

Overview:
- Load/store unit: the initiator side of the data port on the shared 64-bit memory.
- Accepts one memory op from the EX stage via valid/ready and drives the memory's read enable, write enable, address, write data and 64-bit bit-mask.
- Waits a fixed memory latency, then aligns and extends load data.
- Presents the result to WB via valid/ready. Exactly one op is outstanding at a time.

Parameters:
- MEM_LATENCY, 1, cycles `data_r_en`/`data_w_en` are held before `data_r` is sampled; legal range 1..15.
- XLEN, 64, data/address width; fixed at 64.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  EX presents an op
- `ex_ready`  out  1  LSU can accept an op
- `ex_store`  in  1  1 = store, 0 = load
- `ex_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- `ex_unsigned`  in  1  zero-extend load (LBU/LHU/LWU)
- `ex_addr`  in  64  byte address
- `ex_wdata`  in  64  store data, LSB-aligned
- `ex_rd`  in  5  load destination register
- `wb_valid`  out  1  result available
- `wb_ready`  in  1  WB consumes result
- `wb_rdata`  out  64  extended load data; 0 for stores
- `wb_rd`  out  5  destination; 0 for stores and faults
- `wb_misalign`  out  1  address not naturally aligned to `ex_size`
- `data_r_en`  out  1  memory read enable
- `data_w_en`  out  1  memory write enable
- `data_addr`  out  64  doubleword-aligned address {addr[63:3],3'b0}
- `data_w`  out  64  store data shifted to byte lane addr[2:0]
- `data_wmask`  out  64  bit-mask, 8 bits per enabled byte lane
- `data_r`  in  64  memory read data, whole doubleword

Behaviour:
- Reset (async, `rst_n`=0): state IDLE; `ex_ready`=1; `wb_valid`=0; `wb_rdata`=0; `wb_rd`=0; `wb_misalign`=0; `data_r_en`=0; `data_w_en`=0; `data_addr`=0; `data_w`=0; `data_wmask`=0; latency counter=0.
- Reset mid-operation aborts the op. The result is lost. A write already clocked into memory is not undone.
- FSM states:
  - IDLE: `ex_ready`=1. On `ex_valid`: latch op fields.
    - Misaligned → RESP with `wb_misalign`=1; no memory enable is ever asserted.
    - Otherwise → ACCESS with counter=MEM_LATENCY-1.
  - ACCESS: `ex_ready`=0.
    - Load: `data_r_en`=1 for all MEM_LATENCY cycles.
    - Store: `data_w_en`=1 for the first ACCESS cycle only (exactly one write edge).
    - `data_addr`, `data_w` and `data_wmask` are stable throughout ACCESS.
    - Counter decrements each cycle. At counter==0, `data_r` is registered and the state moves to RESP.
  - RESP: `wb_valid`=1; outputs held stable until `wb_ready`. On `wb_valid`&&`wb_ready` → IDLE. No new op is accepted in the same cycle; the next accept is one cycle after the handshake.
- Misalignment: half && a[0]; word && a[1:0]≠0; double && a[2:0]≠0; byte never.
- Byte mask: the mask is 8'h01, 8'h03, 8'h0F or 8'hFF for byte/half/word/double, shifted left by a[2:0]. `data_wmask` expands each mask bit to 8 bits.
- Store data: `data_w` = `ex_wdata` << (8*a[2:0]). Bits outside the mask are don't-care but driven deterministically by the shift.
- Load data: r = `data_r` >> (8*a[2:0]). Truncate r to the access size, then sign-extend from the top bit of the size, or zero-extend when `ex_unsigned`. `ex_unsigned` with size 3 is ignored.
- Latency: a load accepted at edge N has `wb_valid`=1 in cycle N+MEM_LATENCY+1. A misaligned op has `wb_valid`=1 in cycle N+1.
- Memory-side outputs return to 0 in IDLE and RESP; the enables are never asserted outside ACCESS.
- Throughput: at most one op per MEM_LATENCY+2 cycles.

Decomposition:
- Shared package `ysyx_22050243_lsu_pkg`:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - FSM state enum (IDLE, ACCESS, RESP)
  - function size→byte-mask
  - function misaligned(size, a[2:0])
- One natural sub-module: `ysyx_22050243_lsu_align`. It is combinational: store shift/mask expansion and load shift/extend. The FSM and registers stay in the top.

Test Plan:
- LB at 0x8000_0003, `data_r`=64'h0000_0000_8000_0000 (byte lane 3 = 0x80), MEM_LATENCY=1 → `data_addr`=0x8000_0000, `data_r_en` for 1 cycle, `wb_rdata`=64'hFFFF_FFFF_FFFF_FF80 at cycle N+2; LBU → 64'h80.
- SH 0x1234 at 0x8000_0006 → single-cycle `data_w_en`, `data_wmask`=64'hFFFF_0000_0000_0000, `data_w`[63:48]=16'h1234; `wb_valid`=1 with `wb_rd`=0.
- LW at 0x8000_0002 → no `data_r_en`/`data_w_en` ever high; `wb_misalign`=1 at N+1; `wb_rdata`=0.
- MEM_LATENCY=3, LD at 0x8000_0008 → `data_r_en` high exactly 3 cycles; `data_r` sampled on the 3rd; `ex_ready`=0 until the cycle after the WB handshake.
- Hold `wb_ready`=0 for 5 cycles in RESP → `wb_valid`/`wb_rdata` stable; `ex_ready`=0; `ex_valid` pulses are ignored.
- Assert `rst_n`=0 in the 2nd ACCESS cycle of a MEM_LATENCY=3 load → all outputs at reset values immediately; after release an LWU at 0x8000_0004 with `data_r`=64'hDEADBEEF_00000000 completes with 64'h0000_0000_DEAD_BEEF.
